// File: rtl/dumpmem_pkg.sv
// Shared memory-layout constants, FSM encoding and problem base-address helper
// for the problem dump (read-back) path.
// Combinational helpers only; no state lives here.
package dumpmem_pkg;

  localparam int MAX_VERTSBITS = 8;
  localparam int MAX_PROBSBITS = 8;
  localparam int MEM_ADDRBITS  = 16;
  localparam int MEM_PROBSBITS = 4;
  localparam int MEM_WIDTH     = 128;

  // Width of the "words minus one" count; one 128-bit line carries 4 words.
  localparam int NWORDS_BITS   = 2 * MAX_VERTSBITS - 4;
  localparam int LINE_BITS     = MEM_ADDRBITS - MEM_PROBSBITS;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DDR_REQ  = 3'd1,
    S_DDR_WAIT = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Problem slot selects the top address bits; the bitmap lines follow from 0.
  // This must match the layout the fill path writes.
  function automatic logic [MEM_ADDRBITS-1:0] base_addr(input logic [MEM_PROBSBITS-1:0] prob);
    return {prob, {LINE_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/dumpmem_nwords.sv
// nwords_calc: vertex count -> (number of 32-bit bitmap words) - 1.
// Purely combinational; shared with the fill path so both agree on length.
// nverts must be at least 1.
module nwords_calc
  import dumpmem_pkg::*;
(
  input  logic [MAX_VERTSBITS-1:0] nverts,
  output logic [NWORDS_BITS-1:0]   nwords_m1
);

  logic [2*MAX_VERTSBITS-1:0] nv_wide;
  logic [2*MAX_VERTSBITS-1:0] sq_m1;
  logic                       sq_low_unused;

  // nverts^2 - 1, then drop the 5 bit-within-word bits.
  always_comb begin
    nv_wide   = {{MAX_VERTSBITS{1'b0}}, nverts};
    sq_m1     = (nv_wide * nv_wide) - (2*MAX_VERTSBITS)'(1);
    nwords_m1 = {1'b0, sq_m1[2*MAX_VERTSBITS-1:5]};
  end

  assign sq_low_unused = ^sq_m1[4:0];

endmodule

// File: rtl/dumpmem.sv
// dumpmem: reads one problem's adjacency bitmap from DDR and streams it as
// 32-bit words, lane 0 of each 128-bit line first. One read outstanding;
// output holds steady while the consumer stalls, DDR request holds until taken.
module dumpmem
  import dumpmem_pkg::*;
(
  input  logic                     i_clk150,
  input  logic                     i_reset,
  input  logic                     i_go,
  output logic                     o_done,
  input  logic [MAX_PROBSBITS-1:0] i_prob_no,
  input  logic [MAX_VERTSBITS-1:0] i_nverts,
  output logic [31:0]              o_outdata,
  output logic                     o_outdata_have,
  input  logic                     i_outdata_want,
  output logic [MEM_ADDRBITS-1:0]  o_ddr_raddr,
  output logic                     o_ddr_rreq,
  input  logic                     i_ddr_raddr_accept,
  input  logic [MEM_WIDTH-1:0]     i_ddr_rdata,
  input  logic                     i_ddr_rdata_valid
);

  state_t                  state, state_nxt;
  logic [NWORDS_BITS-1:0]  nwords_m1, nwords_m1_r, cnt;
  logic [MEM_ADDRBITS-1:0] addr_cnt;
  logic [MEM_WIDTH-1:0]    unpack_reg;
  logic                    prob_hi_unused;

  assign prob_hi_unused = ^i_prob_no[MAX_PROBSBITS-1:MEM_PROBSBITS];

  nwords_calc u_nwords (
    .nverts    (i_nverts),
    .nwords_m1 (nwords_m1)
  );

  // State register; reset drops straight back to idle from any state.
  always_ff @(posedge i_clk150 or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Datapath: latch run parameters while idle, step address and word counters.
  always_ff @(posedge i_clk150 or posedge i_reset) begin
    if (i_reset) begin
      nwords_m1_r <= '0;
      cnt         <= '0;
      addr_cnt    <= '0;
      unpack_reg  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          nwords_m1_r <= nwords_m1;
          cnt         <= '0;
          addr_cnt    <= base_addr(i_prob_no[MEM_PROBSBITS-1:0]);
        end
        S_DDR_REQ:  if (i_ddr_raddr_accept) addr_cnt <= addr_cnt + MEM_ADDRBITS'(1);
        S_DDR_WAIT: if (i_ddr_rdata_valid)  unpack_reg <= i_ddr_rdata;
        S_DRAIN:    if (i_outdata_want)     cnt <= cnt + NWORDS_BITS'(1);
        default: ;
      endcase
    end
  end

  // Lane select for the current word; the counter's low bits pick the lane.
  always_comb begin
    o_outdata = unpack_reg[{cnt[1:0], 5'b0} +: 32];
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt      = state;
    o_done         = 1'b0;
    o_outdata_have = 1'b0;
    o_ddr_rreq     = 1'b0;
    o_ddr_raddr    = addr_cnt;
    case (state)
      S_IDLE: if (i_go) state_nxt = S_DDR_REQ;
      S_DDR_REQ: begin
        o_ddr_rreq = 1'b1;
        if (i_ddr_raddr_accept) state_nxt = S_DDR_WAIT;
      end
      S_DDR_WAIT: if (i_ddr_rdata_valid) state_nxt = S_DRAIN;
      S_DRAIN: begin
        o_outdata_have = 1'b1;
        if (i_outdata_want) begin
          // Last word wins over "line exhausted" so a partial line ends the run.
          if (cnt == nwords_m1_r)   state_nxt = S_DONE;
          else if (cnt[1:0] == 2'd3) state_nxt = S_DDR_REQ;
        end
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dumpmem.sv
// Bench for dumpmem: DDR responder with fixed latency, scoreboard queues for
// expected read addresses and output words, table of run configurations
// plus hand-written reset / stall / back-to-back sequences.
module tb_dumpmem;
  import dumpmem_pkg::*;

  localparam int LAT = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     go = 1'b0;
  logic                     done;
  logic [MAX_PROBSBITS-1:0] prob_no = '0;
  logic [MAX_VERTSBITS-1:0] nverts = '0;
  logic [31:0]              outdata;
  logic                     have;
  logic                     want = 1'b0;
  logic [MEM_ADDRBITS-1:0]  raddr;
  logic                     rreq;
  logic                     accept = 1'b0;
  logic [MEM_WIDTH-1:0]     rdata = '0;
  logic                     rvalid = 1'b0;

  always #5 clk = ~clk;

  dumpmem dut (
    .i_clk150           (clk),
    .i_reset            (rst),
    .i_go               (go),
    .o_done             (done),
    .i_prob_no          (prob_no),
    .i_nverts           (nverts),
    .o_outdata          (outdata),
    .o_outdata_have     (have),
    .i_outdata_want     (want),
    .o_ddr_raddr        (raddr),
    .o_ddr_rreq         (rreq),
    .i_ddr_raddr_accept (accept),
    .i_ddr_rdata        (rdata),
    .i_ddr_rdata_valid  (rvalid)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0]             q_words[$];
  logic [MEM_ADDRBITS-1:0] q_addrs[$];
  int   done_cnt = 0;
  int   xfers = 0;
  bit   accept_en = 1'b1;
  int   inj_req = 0;
  logic [3:0] wpat = 4'hF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [31:0] gen(input logic [MEM_ADDRBITS-1:0] line, input int lane);
    return {line, 8'(lane), line[7:0] ^ 8'h5A};
  endfunction

  function automatic logic [MEM_WIDTH-1:0] line_data(input logic [MEM_ADDRBITS-1:0] line);
    return {gen(line, 3), gen(line, 2), gen(line, 1), gen(line, 0)};
  endfunction

  // Monitor + DDR/consumer model, evaluated on the falling edge.
  initial begin
    int ddr_cd = 0;
    int inj_ack = 0;
    int widx = 0;
    logic [MEM_ADDRBITS-1:0] ddr_addr = '0;
    logic [MEM_ADDRBITS-1:0] prev_raddr = '0;
    logic [31:0] prev_dat = '0;
    bit prev_rq_stall = 1'b0;
    bit prev_stall = 1'b0;
    bit exp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        accept = 1'b0;
        rvalid = 1'b0;
        prev_rq_stall = 1'b0;
        prev_stall = 1'b0;
        exp_done = 1'b0;
      end else begin
        rvalid = 1'b0;
        if (ddr_cd > 0) begin
          ddr_cd--;
          if (ddr_cd == 0) begin
            rvalid = 1'b1;
            rdata  = line_data(ddr_addr);
          end
        end else if (inj_req != inj_ack) begin
          rvalid  = 1'b1;
          rdata   = {4{32'hDEADBEEF}};
          inj_ack = inj_req;
        end
        if (prev_rq_stall) begin
          chk("rreq_hold", 32'(rreq), 32'd1);
          chk("raddr_hold", 32'(raddr), 32'(prev_raddr));
        end
        accept = rreq & accept_en;
        if (rreq && accept) begin
          if (q_addrs.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_read: raddr %h, no read expected", raddr);
          end else begin
            chk("raddr", 32'(raddr), 32'(q_addrs.pop_front()));
          end
          ddr_cd   = LAT;
          ddr_addr = raddr;
        end
        prev_rq_stall = rreq & ~accept;
        prev_raddr    = raddr;
        if (done || exp_done) chk("done", 32'(done), 32'(exp_done));
        if (done) done_cnt++;
        exp_done = 1'b0;
        want = wpat[2'(widx)];
        widx++;
        if (prev_stall && have) chk("stable", outdata, prev_dat);
        if (have && want) begin
          if (q_words.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_word: got %h, no word expected", outdata);
          end else begin
            chk("word", outdata, q_words.pop_front());
            xfers++;
            if (q_words.size() == 0) exp_done = 1'b1;
          end
        end
        prev_stall = have & ~want;
        prev_dat   = outdata;
      end
    end
  end

  task automatic push_expect(input logic [MEM_ADDRBITS-1:0] base, input int nw);
    for (int l = 0; l < (nw + 3) / 4; l++) q_addrs.push_back(base + MEM_ADDRBITS'(l));
    for (int k = 0; k < nw; k++) q_words.push_back(gen(base + MEM_ADDRBITS'(k / 4), k % 4));
  endtask

  // Called at posedge+2 with the DUT idle; returns at posedge+2 after done.
  task automatic run(input logic [7:0] p, input logic [7:0] n, input logic [15:0] base,
                     input int nw, input logic [3:0] pat, input bit busy_go, input int acc_stall);
    int d0;
    bit got;
    push_expect(base, nw);
    wpat = pat;
    d0 = done_cnt;
    if (acc_stall > 0) accept_en = 1'b0;
    go = 1'b1; prob_no = p; nverts = n;
    @(posedge clk); #1;
    chk("rreq_lat", 32'(rreq), 32'd1);
    go = 1'b0;
    prob_no = 8'($urandom);
    nverts  = 8'($urandom_range(1, 255));
    if (acc_stall > 0) begin
      repeat (acc_stall) @(posedge clk);
      #2;
      inj_req++;
      @(posedge clk); #2;
      chk("no_early_data", 32'(have), 32'd0);
      chk("rreq_still", 32'(rreq), 32'd1);
      accept_en = 1'b1;
    end
    if (busy_go) begin
      repeat (6) @(posedge clk);
      #2 go = 1'b1;
      @(posedge clk);
      #2 go = 1'b0;
    end
    got = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (done_cnt != d0) begin got = 1'b1; break; end
      @(posedge clk);
    end
    #2;
    if (!got) begin
      fail("timeout_waiting_done");
      q_words.delete();
      q_addrs.delete();
    end
    chk("words_left", 32'(q_words.size()), 32'd0);
    chk("reads_left", 32'(q_addrs.size()), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  prob;
    logic [7:0]  nv;
    logic [15:0] base;
    int          nwords;
    logic [3:0]  wpat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int x0;
    vecs[0] = '{8'd2,   8'd16,  16'h2000, 8,    4'b1111};
    vecs[1] = '{8'd0,   8'd5,   16'h0000, 1,    4'b1111};
    vecs[2] = '{8'd0,   8'd8,   16'h0000, 2,    4'b1001};
    vecs[3] = '{8'd5,   8'd1,   16'h5000, 1,    4'b1111};
    vecs[4] = '{8'd7,   8'd12,  16'h7000, 5,    4'b0101};
    vecs[5] = '{8'd9,   8'd13,  16'h9000, 6,    4'b1111};
    vecs[6] = '{8'd15,  8'd32,  16'hF000, 32,   4'b1011};
    vecs[7] = '{8'h13,  8'd16,  16'h3000, 8,    4'b1111};
    vecs[8] = '{8'd4,   8'd255, 16'h4000, 2033, 4'b1111};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_have", 32'(have), 32'd0);
    chk("rst_rreq", 32'(rreq), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;

    for (int i = 0; i < 9; i++)
      run(vecs[i].prob, vecs[i].nv, vecs[i].base, vecs[i].nwords, vecs[i].wpat, 1'b0, 0);

    // Spurious read data while idle must not start anything.
    inj_req++;
    repeat (3) @(posedge clk);
    #2;
    chk("idle_spurious_have", 32'(have), 32'd0);
    chk("idle_spurious_rreq", 32'(rreq), 32'd0);

    // Request not accepted for 5 cycles, spurious data during the stall.
    run(8'd6, 8'd8, 16'h6000, 2, 4'b1111, 1'b0, 5);

    // Reset while draining, after two words have gone out.
    push_expect(16'h2000, 8);
    wpat = 4'b1111;
    x0 = xfers;
    go = 1'b1; prob_no = 8'd2; nverts = 8'd16;
    @(posedge clk);
    #2 go = 1'b0;
    for (int c = 0; c < 200 && xfers < x0 + 2; c++) @(posedge clk);
    #2;
    chk("xfers_before_reset", 32'(xfers - x0), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_have", 32'(have), 32'd0);
    chk("mid_rst_rreq", 32'(rreq), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    q_words.delete();
    q_addrs.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    inj_req++;
    repeat (3) @(posedge clk);
    #2;
    chk("post_rst_have", 32'(have), 32'd0);
    chk("post_rst_rreq", 32'(rreq), 32'd0);
    run(8'd2, 8'd16, 16'h2000, 8, 4'b1111, 1'b0, 0);

    // Back-to-back runs with a stray go while busy.
    run(8'd1, 8'd16, 16'h1000, 8, 4'b1111, 1'b1, 0);
    run(8'd3, 8'd16, 16'h3000, 8, 4'b1111, 1'b1, 0);
    repeat (4) @(posedge clk);
    #2;
    chk("final_idle_rreq", 32'(rreq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dumpmem.md
Name: dumpmem

Overview:
- Read-side counterpart of the problem-fill path. On i_go, reads one problem's adjacency bitmap back out of DDR and streams it as 32-bit words.
- Each 128-bit DDR line is fetched from the problem's base address, then unpacked into 32-bit words, lane 0 (bits 31:0) first.
- Sits between the DDR read port and the host/result output FIFO.
- Emits exactly ceil(nverts²/32) words.

Parameters:
- None local. Uses shared defines: MAX_VERTSBITS, MAX_PROBSBITS, MEM_ADDRBITS, MEM_PROBSBITS, MEM_WIDTH (=128).

Ports:
- i_clk150  in  1  clock; all state on rising edge
- i_reset  in  1  reset, asynchronous, active-high; clock i_clk150
- i_go  in  1  start; sampled only in S_IDLE
- o_done  out  1  one-cycle pulse after the final word is accepted
- i_prob_no  in  MAX_PROBSBITS  problem slot; low MEM_PROBSBITS bits used
- i_nverts  in  MAX_VERTSBITS  vertex count, must be ≥1; sampled in S_IDLE
- o_outdata  out  32  output word
- o_outdata_have  out  1  o_outdata valid
- i_outdata_want  in  1  consumer ready; transfer when have & want
- o_ddr_raddr  out  MEM_ADDRBITS  read line address
- o_ddr_rreq  out  1  read request
- i_ddr_raddr_accept  in  1  request taken this cycle
- i_ddr_rdata  in  MEM_WIDTH  read data line
- i_ddr_rdata_valid  in  1  one-cycle pulse, i_ddr_rdata valid

Behaviour:
- Reset: state=S_IDLE, word counter=0. Outputs: o_done=0, o_outdata_have=0, o_ddr_rreq=0. o_outdata and o_ddr_raddr are don't-care whenever their qualifier is low.
- All outputs are combinational from state and registers. Handshake inputs act in the same cycle.
- Word count: nwords_m1 = (nverts*nverts - 1) >> 5, width 2*MAX_VERTSBITS-4. Examples: n=5 gives 0; n=8 gives 1; n=16 gives 7.
- Base address: {i_prob_no[MEM_PROBSBITS-1:0], zeros}. This is the same layout fillmem writes.
- S_IDLE:
  - Every cycle: load nwords_m1, clear word counter, load addr_cnt = base.
  - i_go=1 → S_DDR_REQ.
- S_DDR_REQ:
  - o_ddr_rreq=1, o_ddr_raddr=addr_cnt.
  - On i_ddr_raddr_accept: addr_cnt++, → S_DDR_WAIT.
  - Otherwise hold the request and the address stable.
- S_DDR_WAIT:
  - On i_ddr_rdata_valid: unpack_reg ← i_ddr_rdata, → S_DRAIN.
  - At most one read is outstanding.
- S_DRAIN:
  - o_outdata_have=1, o_outdata = unpack_reg lane cnt[1:0] (lane k = bits 32k+31:32k).
  - On i_outdata_want: cnt++. Then:
    - cnt==nwords_m1 → S_DONE (takes priority);
    - else cnt[1:0]==3 → S_DDR_REQ;
    - else stay.
  - Data must stay stable while have=1 and want=0.
- S_DONE: o_done=1 for one cycle, → S_IDLE. A new i_go is accepted on the following S_IDLE cycle.
- Latency:
  - i_go in S_IDLE at cycle 0 → o_ddr_rreq high at cycle 1.
  - Accept at cycle a → S_DDR_WAIT from a+1.
  - rdata_valid at cycle r → o_outdata_have from r+1.
- Partial last line: unused upper lanes are never emitted.
- i_ddr_rdata_valid outside S_DDR_WAIT is ignored. This covers stale responses after a mid-operation reset.
- i_go outside S_IDLE is ignored.
- Reset mid-operation: immediate return to S_IDLE with have/rreq/done low. No partial o_done.
- Undefined states → S_IDLE.

Decomposition:
- defs.vh holds MEM_*, MAX_* defines. Add the state encoding as localparams in the module.
- One natural sub-module: nwords_calc (nverts → nwords_m1, combinational multiply). Shared with fillmem so that fill and dump lengths cannot diverge.

Test Plan:
- n=16, prob 2, memory latency 3, want always 1:
  - reads at base(2) and base(2)+1;
  - 8 words in lane order 0..3 per line;
  - o_done one cycle after the 8th transfer.
- n=5:
  - one read, exactly 1 word (bits 31:0);
  - lanes 1-3 never appear;
  - o_done follows.
- n=8 with want toggling 1,0,0,1:
  - 2 words;
  - o_outdata stable while stalled;
  - no duplicate or skipped words.
- i_ddr_raddr_accept held low 5 cycles: rreq stays high and raddr stays constant; no rdata is consumed early. A spurious rdata_valid pulse in S_IDLE is ignored.
- Assert i_reset during S_DRAIN after word 2 of n=16:
  - outputs drop low;
  - late rdata_valid is ignored;
  - a new i_go restarts at base with word 0.
- Back-to-back runs, prob 1 then prob 3: both address ranges correct, and i_go asserted during the busy phase is ignored.
